// File: rtl/pattern_detector_cfg_pkg.sv
// Shared types and constants for the configurable serial pattern detector.
package pattern_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    // Width needed to hold a length in the range 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_cfg_if.sv
// Stream, configuration and status bundle between a driver and the detector.
interface pattern_detector_cfg_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    import pattern_det_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);

    logic               in_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  z, match_count, cfg_err
    );

    modport slave (
        input  in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output z, match_count, cfg_err
    );

endinterface

// File: rtl/pattern_detector_cfg_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count increments, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pattern_detector_cfg.sv
// Serial pattern detector with run-time pattern, length and overlap mode;
// history is a shift register compared against the pattern under a length mask.
module pattern_detector_cfg
    import pattern_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    pattern_detector_cfg_if.slave bus
);

    localparam int LEN_W = len_w(MAX_LEN);

    state_t             state_r;
    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   fill_r;
    logic               overlap_r;
    logic               cfg_err_r;
    logic               z_r;

    logic               legal_s;
    logic               accept_s;
    logic               match_s;
    logic [MAX_LEN-1:0] hist_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [MAX_LEN-1:0] cfg_mask_s;
    logic [LEN_W-1:0]   fill_inc_s;

    // Length masks for the active pattern and for an incoming configuration.
    always_comb begin
        mask_s     = {MAX_LEN{1'b0}};
        cfg_mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i]     = (i < int'(len_r));
            cfg_mask_s[i] = (i < int'(bus.cfg_len));
        end
    end

    // Bit acceptance and match decision, including the bit being accepted now.
    always_comb begin
        legal_s     = (bus.cfg_len != {LEN_W{1'b0}}) && (int'(bus.cfg_len) <= MAX_LEN);
        accept_s    = bus.in_valid && (state_r != IDLE) && !bus.cfg_load;
        hist_next_s = {hist_r[MAX_LEN-2:0], bus.x};
        fill_inc_s  = (int'(fill_r) >= MAX_LEN) ? fill_r : (fill_r + LEN_W'(1));
        match_s     = accept_s && (fill_inc_s >= len_r) &&
                      (((hist_next_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Control FSM with configuration latch, history and fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pat_r     <= {MAX_LEN{1'b0}};
            hist_r    <= {MAX_LEN{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            overlap_r <= 1'b0;
            cfg_err_r <= 1'b0;
            z_r       <= 1'b0;
        end else if (bus.cfg_load) begin
            // A load wins over any bit presented in the same cycle.
            if (legal_s) begin
                pat_r     <= bus.cfg_pattern & cfg_mask_s;
                len_r     <= bus.cfg_len;
                overlap_r <= bus.cfg_overlap;
                hist_r    <= {MAX_LEN{1'b0}};
                fill_r    <= {LEN_W{1'b0}};
                cfg_err_r <= 1'b0;
                state_r   <= HUNT;
            end else begin
                cfg_err_r <= 1'b1;
                state_r   <= IDLE;
            end
            z_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                    z_r     <= 1'b0;
                end
                HUNT, HIT: begin
                    if (accept_s) begin
                        hist_r <= hist_next_s;
                        // Non-overlapping mode demands a full fresh pattern after a hit.
                        fill_r <= (match_s && !overlap_r) ? {LEN_W{1'b0}} : fill_inc_s;
                    end else begin
                        hist_r <= hist_r;
                        fill_r <= fill_r;
                    end
                    state_r <= match_s ? HIT : HUNT;
                    z_r     <= match_s;
                end
                default: begin
                    state_r <= IDLE;
                    z_r     <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_s),
        .count (bus.match_count)
    );

    assign bus.z       = z_r;
    assign bus.cfg_err = cfg_err_r;

endmodule

// File: doc/pattern_detector_cfg.md
PATTERN_DETECTOR_CFG -- requirements
Module: pattern_detector_cfg

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have derived constant LEN_W = $clog2(MAX_LEN+1).
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: x is sampled only when high.
REQ-007 SHALL have port x, input, 1: serial data bit.
REQ-008 SHALL have port cfg_load, input, 1: one-cycle strobe that latches cfg_* and restarts detection.
REQ-009 SHALL have port cfg_pattern, input, MAX_LEN: pattern; bit cfg_len-1 is the first bit received and bit 0 the last.
REQ-010 SHALL have port cfg_len, input, LEN_W: pattern length.
REQ-011 SHALL have port cfg_overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port z, output, 1: Moore match flag.
REQ-013 SHALL have port match_count, output, CNT_W: saturating count of matches.
REQ-014 SHALL have port cfg_err, output, 1: the last cfg_load carried an illegal length.

Function
REQ-015 SHALL implement FSM states IDLE, HUNT and HIT, with z = 1 only in HIT.
REQ-016 SHALL drive z from the state register alone (Moore) and never combinationally from x.
REQ-017 SHALL, on cfg_load with 1 <= cfg_len <= MAX_LEN, latch pattern, length and mode, clear history and fill count, clear cfg_err, and go to HUNT next cycle.
REQ-018 SHALL, on cfg_load with cfg_len = 0 or cfg_len > MAX_LEN, set cfg_err, go to IDLE, and keep match_count.
REQ-019 SHALL, in IDLE, ignore x and in_valid.
REQ-020 SHALL, on each accepted bit (in_valid = 1, state HUNT or HIT), shift x into history bit 0 and increment the fill count, saturating at MAX_LEN.
REQ-021 SHALL declare a match when fill >= len and history[len-1:0] equals pattern[len-1:0], both evaluated including the bit just accepted.
REQ-022 SHALL, on a match, enter HIT in the cycle after the accepting edge (latency 1), so z is high for exactly one cycle per match.
REQ-023 SHALL return from HIT to HUNT when no further match occurs on the next edge, and stay in HIT when a back-to-back match occurs.
REQ-024 SHALL, in HIT with in_valid = 0, return to HUNT with no match.
REQ-025 SHALL, with cfg_overlap = 1, keep history after a match so matches can share bits.
REQ-026 SHALL, with cfg_overlap = 0, reset the fill count to 0 after a match so the next match needs len fresh bits.
REQ-027 SHALL increment match_count by 1 per match and hold it at 2^CNT_W-1.
REQ-028 SHALL, when cfg_load and an accepted bit coincide, give cfg_load priority and discard the bit.
REQ-029 SHALL ignore cfg_pattern bits at index cfg_len and above.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously force state IDLE, z = 0, match_count = 0, cfg_err = 0, history = 0, fill = 0, and latched config = 0.
REQ-031 SHALL, after reset release, stay in IDLE until a legal cfg_load.
REQ-032 SHALL abort any partial match on reset mid-stream and leave no residual z pulse.

Structure
REQ-033 SHALL define the state enum (IDLE/HUNT/HIT) and LEN_W computation in shared package pattern_det_pkg.
REQ-034 SHALL place the saturating counter in one sub-module, sat_counter, parameterised by width.
REQ-035 SHALL implement history as a MAX_LEN-bit shift register with masked compare; no per-pattern hard-coded states.

Verification
REQ-036 SHALL cover: pattern 4'b1010, len 4, overlap = 1, bits 1,0,1,0,1,0 -> z high after bits 4 and 6, match_count = 2.
REQ-037 SHALL cover: same stream with overlap = 0 -> z high only after bit 4, match_count = 1.
REQ-038 SHALL cover: len 4 pattern 1010, bits 1,0 then in_valid low 3 cycles then bits 1,0 -> one z pulse with no loss across the gaps.
REQ-039 SHALL cover: len 1 pattern 1, stream 1,1,1 -> z high 3 consecutive cycles; with CNT_W = 2 and 5 matches -> match_count = 3.
REQ-040 SHALL cover: cfg_len = 0 -> cfg_err = 1, state IDLE, z stays 0; then a legal load -> cfg_err = 0.
REQ-041 SHALL cover: rst_n low after bits 1,0,1, release, reload, send 0 -> no z pulse, match_count = 0.
